// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/ack fetch and valid/ready instruction hold with branch redirect
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic [8:0]        functCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4
);
  typedef enum logic [1:0] {RESET_ST, REQ, HOLD} state_e;
  state_e state_q, state_d;
  logic rel_q, rel_d, req_q, req_d, valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d, tgt;
  logic [31:0] instr_q, instr_d;
  logic unused_ok;
  assign tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_ok = ^redirect_pc[1:0];
  // rel_q marks the first cycle after reset release so RESET_ST lasts one full cycle
  always_comb begin
    state_d = state_q;
    rel_d = 1'b1;
    req_d = req_q;
    valid_d = valid_q;
    pc_d = pc_q;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      RESET_ST: begin
        state_d = rel_q ? REQ : RESET_ST;
        req_d = rel_q;
      end
      REQ: begin
        pc_d = redirect_valid ? tgt : pc_q;
        if (!redirect_valid && imem_ack) begin
          state_d = HOLD;
          req_d = 1'b0;
          valid_d = 1'b1;
          instr_d = imem_rdata;
          instr_pc_d = pc_q;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          state_d = REQ;
          req_d = 1'b1;
          valid_d = 1'b0;
          pc_d = redirect_valid ? tgt : pc_q + ADDR_W'(4);
        end
      end
      default: begin
        state_d = RESET_ST;
        req_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_ST;
      rel_q <= 1'b0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      pc_q <= RESET_PC;
      instr_q <= '0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      rel_q <= rel_d;
      req_q <= req_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = pc_q;
  assign instr_valid = valid_q;
  assign instr = instr_q;
  assign opCode = instr_q[31:26];
  assign functCode = instr_q[8:0];
  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];
  assign imm = instr_q[15:0];
  assign instr_pc = instr_pc_q;
  assign pc_plus4 = instr_pc_q + ADDR_W'(4);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed fetch/hold/redirect vectors with a scoreboard-checked decode side
module tb_instr_fetch_unit;
  logic clk, rst, imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, pc_plus4;
  logic [5:0] opCode;
  logic [8:0] functCode;
  logic [4:0] rs, rt;
  logic [15:0] imm;
  int errs = 0, chks = 0;
  logic [63:0] sb_q[$];
  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opCode(opCode), .functCode(functCode), .rs(rs), .rt(rt),
    .imm(imm), .instr_pc(instr_pc), .pc_plus4(pc_plus4)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic a, input logic [31:0] d, input logic r, input logic rv, input logic [31:0] rp);
    imem_ack = a;
    imem_rdata = d;
    instr_ready = r;
    redirect_valid = rv;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, pc);
    sb_q.push_back({pc, word});
    step(1'b1, word, 1'b1, 1'b0, 32'h0);
    chk("valid_after_ack", instr_valid, 1);
    chk("req_in_hold", imem_req, 0);
  endtask
  task automatic accept(input logic [31:0] next);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("valid_drop", instr_valid, 0);
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, next);
  endtask
  initial begin
    rst = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    rst = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (rst && instr_valid && instr_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_instr_pc", instr_pc, 32'hxxxx_xxxx);
          end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            chk("sb_instr", instr, e[31:0]);
            chk("sb_instr_pc", instr_pc, e[63:32]);
            chk("sb_pc_plus4", pc_plus4, e[63:32] + 32'd4);
            chk("sb_opcode", opCode, e[31:26]);
            chk("sb_funct", functCode, e[8:0]);
            chk("sb_rs_rt", {rs, rt}, e[25:16]);
          end
        end
      end
      begin
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("release_req_low", imem_req, 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h500);
        chk("first_req", imem_req, 1);
        chk("redirect_ignored_in_reset", imem_addr, 32'h0);
        fetch(32'h0, 32'h2000_0040);
        chk("opcode_hand", opCode, 6'b001000);
        chk("funct_hand", functCode, 9'b001000000);
        chk("rs_hand", rs, 0);
        chk("rt_hand", rt, 0);
        chk("imm_hand", imm, 16'h0040);
        accept(32'h4);
        fetch(32'h4, 32'h0123_4567);
        accept(32'h8);
        fetch(32'h8, 32'h89AB_CDEF);
        accept(32'hC);
        fetch(32'hC, 32'h8C43_0010);
        for (int i = 0; i < 5; i++) begin
          step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
          chk("stall_valid", instr_valid, 1);
          chk("stall_req", imem_req, 0);
          chk("stall_instr", instr, 32'h8C43_0010);
          chk("stall_rs_rt", {rs, rt}, 10'b00010_00011);
        end
        accept(32'h10);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h103);
        chk("redir_req_valid", instr_valid, 0);
        chk("redir_req_req", imem_req, 1);
        chk("redir_req_addr", imem_addr, 32'h100);
        fetch(32'h100, 32'h1111_2222);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        chk("redir_hold_valid", instr_valid, 0);
        chk("redir_hold_addr", imem_addr, 32'h40);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("redir_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h3333_4444);
        accept(32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_pc_plus4", pc_plus4, 32'h4);
        chk("sb_drained", sb_q.size(), 0);
        step(1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
        chk("rst_held_req", imem_req, 0);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
